// File: rtl/imu_pkt_pkg.sv
// Shared constants, FSM encodings and baud helper for the IMU packet receiver.
package imu_pkt_pkg;

  localparam logic [7:0] PKT_HDR   = 8'hAA;
  localparam int         PKT_BYTES = 4;

  localparam logic [2:0] R_IDLE      = 3'd0;
  localparam logic [2:0] R_START     = 3'd1;
  localparam logic [2:0] R_DATA      = 3'd2;
  localparam logic [2:0] R_STOP      = 3'd3;
  localparam logic [2:0] R_WAIT_HIGH = 3'd4;

  localparam logic [1:0] P_HUNT  = 2'd0;
  localparam logic [1:0] P_LSB   = 2'd1;
  localparam logic [1:0] P_MSB   = 2'd2;
  localparam logic [1:0] P_FLAGS = 2'd3;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, stop-bit framing check.
module uart_rx
  import imu_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);

  logic          r_sync1, r_sync2, r_rx_prev;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_valid, r_frame_err;

  logic w_fall, w_half_done, w_bit_done;

  assign w_fall      = r_rx_prev & ~r_sync2;
  assign w_half_done = (r_cnt == CW'(HALF - 1));
  assign w_bit_done  = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_state      <= R_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= rx;
      r_sync2      <= r_sync1;
      r_rx_prev    <= r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_cnt        <= r_cnt + CW'(1);
      case (r_state)
        R_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= R_START;
        end
        R_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (w_half_done) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= R_STOP;
          end
        end
        R_STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
              r_state      <= R_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= R_WAIT_HIGH;
            end
          end
        end
        R_WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_sync2) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign rx_data    = r_shift;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/imu_packet_rx.sv
// IMU packet receiver: AA/LSB/MSB/flags parser with inter-byte timeout.
// Optional good/error counters are built when IMU_PKT_STATS_EN is defined.
module imu_packet_rx
  import imu_pkt_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int CLK_FREQ_HZ   = 1_840_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int TIMEOUT_BYTES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic [WIDTH-1:0] sample_out,
  output logic             event_out,
  output logic             pkt_valid,
  output logic             frame_err,
  output logic             sync_err,
  output logic [15:0]      pkt_count,
  output logic [15:0]      err_count
);

  localparam int CPB         = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * CPB;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] w_rx_data;
  logic       w_byte_valid, w_frame_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_uart_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (w_rx_data),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err)
  );

  logic [1:0]       r_pstate;
  logic [7:0]       r_lsb, r_msb;
  logic [TW-1:0]    r_idle_cnt;
  logic [WIDTH-1:0] r_sample;
  logic             r_event, r_pkt_valid, r_sync_err, r_frame_err;

  logic [15:0] w_word;
  logic        w_timeout, w_flags_ok;

  assign w_word     = {r_msb, r_lsb};
  assign w_flags_ok = (w_rx_data[7:1] == 7'd0);
  // Frame errors take priority so the two error pulses never coincide.
  assign w_timeout  = (r_pstate != P_HUNT) && (r_idle_cnt == TW'(TIMEOUT_CYC)) &&
                      !w_byte_valid && !w_frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pstate    <= P_HUNT;
      r_lsb       <= '0;
      r_msb       <= '0;
      r_idle_cnt  <= '0;
      r_sample    <= '0;
      r_event     <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_frame_err <= w_frame_err;

      if (r_pstate == P_HUNT || w_byte_valid) r_idle_cnt <= '0;
      else if (r_idle_cnt != TW'(TIMEOUT_CYC)) r_idle_cnt <= r_idle_cnt + TW'(1);

      if (w_frame_err) begin
        r_pstate <= P_HUNT;
      end else if (w_timeout) begin
        r_pstate   <= P_HUNT;
        r_sync_err <= 1'b1;
      end else if (w_byte_valid) begin
        case (r_pstate)
          P_HUNT: if (w_rx_data == PKT_HDR) r_pstate <= P_LSB;
          P_LSB: begin
            r_lsb    <= w_rx_data;
            r_pstate <= P_MSB;
          end
          P_MSB: begin
            r_msb    <= w_rx_data;
            r_pstate <= P_FLAGS;
          end
          default: begin
            r_pstate <= P_HUNT;
            if (w_flags_ok) begin
              r_pkt_valid <= 1'b1;
              r_sample    <= w_word[WIDTH-1:0];
              r_event     <= w_rx_data[0];
            end else begin
              r_sync_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign sample_out = r_sample;
  assign event_out  = r_event;
  assign pkt_valid  = r_pkt_valid;
  assign frame_err  = r_frame_err;
  assign sync_err   = r_sync_err;

`ifdef IMU_PKT_STATS_EN
  logic [15:0] r_pkt_count, r_err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (r_pkt_valid) r_pkt_count <= r_pkt_count + 16'd1;
      if (r_frame_err | r_sync_err) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: doc/imu_packet_rx.md
# imu_packet_rx

Receive-side counterpart of the IMU UART link. Deserialises the 8N1 byte stream on `rx` and locks onto the 4-byte packet format: 0xAA header, sample LSB, sample MSB, flags with bit0 = event. It re-emits each decoded sample with a one-cycle valid strobe and reports line and packet errors. It sits at the far end of the serial line, or in a loopback bench, and feeds downstream logging and checking logic.

## Interface
Parameters:
- `WIDTH`, 16, sample width; must be ≤16; `sample_out` takes bits [WIDTH-1:0] of {MSB,LSB}.
- `CLK_FREQ_HZ`, 1_840_000, clk frequency.
- `BAUD_RATE`, 115_200, line rate.
- `TIMEOUT_BYTES`, 2, maximum idle gap between bytes of one packet, in byte times.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `sample_out`  out  WIDTH  last good sample; holds between packets.
- `event_out`  out  1  event flag of the last good packet.
- `pkt_valid`  out  1  one-cycle pulse when `sample_out`/`event_out` update.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled as 0.
- `sync_err`  out  1  one-cycle pulse for a malformed flags byte or an inter-byte timeout.
- `pkt_count`  out  16  good-packet counter (macro only).
- `err_count`  out  16  frame_err + sync_err event counter (macro only).

## Operation
- `CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE`, which is 16 at the defaults.
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- Byte receiver states: R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH.
  - R_IDLE: a synchronised falling edge enters R_START.
  - R_START: waits CLKS_PER_BIT/2 cycles. If the line is low, go to R_DATA; if high, it was a glitch, so return to R_IDLE.
  - R_DATA: samples 8 bits LSB-first, one every CLKS_PER_BIT cycles.
  - R_STOP: samples the stop bit after CLKS_PER_BIT cycles. A 1 gives a `byte_valid` pulse and returns to R_IDLE. A 0 gives a `frame_err` pulse, discards the byte, and goes to R_WAIT_HIGH.
  - R_WAIT_HIGH: returns to R_IDLE once the line is sampled high.
- Packet parser states: P_HUNT, P_LSB, P_MSB, P_FLAGS.
  - P_HUNT: discards every byte except 0xAA; 0xAA moves to P_LSB.
  - P_LSB: latches the byte as LSB and moves to P_MSB.
  - P_MSB: latches the byte as MSB and moves to P_FLAGS.
  - P_FLAGS: if byte[7:1] == 0, updates the outputs and pulses `pkt_valid`. Otherwise pulses `sync_err` and drops the packet. Either way returns to P_HUNT.
- Parsing is positional once the header is found, so 0xAA appearing as LSB, MSB or data is legal.
- Parser error handling:
  - `frame_err` in any parser state forces P_HUNT; the partial packet is dropped.
  - In P_LSB, P_MSB or P_FLAGS, an idle gap greater than `TIMEOUT_BYTES*10*CLKS_PER_BIT` cycles since the last `byte_valid` forces P_HUNT with a `sync_err` pulse.
  - The timeout counter saturates and is inactive in P_HUNT.
- Reset mid-byte or mid-packet: all state returns to R_IDLE/P_HUNT, outputs clear, and the partial frame is lost. The bytes of the interrupted packet that are still in flight after reset are discarded until the next 0xAA.

## Timing
- Reset values: all outputs are 0; `sample_out` is 0.
- Stop-bit sample point: synchronised falling edge + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles. The synchroniser adds 2 cycles of `rx` latency on top.
- `pkt_valid`, `sample_out` and `event_out` are registered. They update 1 cycle after the flags-byte `byte_valid`.
- `frame_err` is asserted on the stop-sample cycle.
- `sync_err` is asserted 1 cycle after the offending byte, or on the timeout cycle.
- Error pulses are mutually exclusive per cycle by construction.
- Back-to-back packets with zero idle bits are accepted with no dropped bytes.

## Configuration
- `IMU_PKT_STATS_EN` defined:
  - `pkt_count` increments on each `pkt_valid`.
  - `err_count` increments on each `frame_err` or `sync_err`.
  - Both wrap at 16'hFFFF → 0 and reset to 0.
- Not defined: `pkt_count` and `err_count` are tied to 0 and no counter flops are inferred.

## Structure
- Package `imu_pkt_pkg` holds:
  - `PKT_HDR` = 8'hAA;
  - `PKT_BYTES` = 4;
  - the parser state encoding;
  - the byte-receiver state encoding;
  - a `clks_per_bit` constant function.
- Sub-module `uart_rx`: synchroniser plus byte receiver, with outputs `rx_data[7:0]`, `byte_valid` and `frame_err`. `imu_packet_rx` contains the parser, timeout and stats logic.

## Test plan
- Send packets AA 05 00 01, then AA 0A 00 00 → `pkt_valid` ×2; sample 5/event 1, then sample 10/event 0.
- Send garbage 12 34 followed by AA AA 00 01 → exactly one `pkt_valid`; sample 0x00AA, event 1.
- Send AA 05 00 03 → `sync_err` pulse, no `pkt_valid`, outputs retain previous values.
- Send AA 05, then idle for 25 byte times → `sync_err` pulse; the following AA 07 00 00 decodes sample 7.
- Send AA 05 with the MSB stop bit forced to 0 → `frame_err`; the following good packet decodes. With `IMU_PKT_STATS_EN`: `err_count`=1, `pkt_count`=1.
- Assert `rst_n` low in the middle of the MSB byte → all outputs are 0. The next full packet AA 09 00 01 decodes correctly.
